// File: rtl/tiny32_bus_arbiter.sv
// tiny32_bus_arbiter
// Two-master round-robin arbiter for the tiny32 memory bus. One master owns
// the shared slave bus at a time; its address/data/strobes are muxed onto the
// slave side and the slave ready/data are routed back to it alone. A per
// transfer watchdog completes accesses that the slave never acknowledges,
// returning ERROR_DATA and raising a sticky error flag.
module tiny32_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  // master 0
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_out,
  output logic [31:0] m0_data_in,
  input  logic        m0_nrd,
  input  logic [3:0]  m0_nwr,
  output logic        m0_ready,
  // master 1
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_out,
  output logic [31:0] m1_data_in,
  input  logic        m1_nrd,
  input  logic [3:0]  m1_nwr,
  output logic        m1_ready,
  // shared slave bus
  output logic [31:0] s_address,
  output logic [31:0] s_data_out,
  output logic        s_nrd,
  output logic [3:0]  s_nwr,
  input  logic [31:0] s_data_in,
  input  logic        s_ready,
  // status
  output logic [1:0]  grant,
  output logic        timeout_error,
  output logic        timeout_master,
  input  logic        clear_error
);

  // Watchdog counter width: wide enough to reach TIMEOUT_CYCLES-1, never
  // narrower than 8 bits and never wider than 32 bits.
  localparam int unsigned WD_W_RAW = $clog2({32'd0, TIMEOUT_CYCLES} + 64'd1);
  localparam int unsigned WD_W     = (WD_W_RAW < 8)  ? 8 :
                                     (WD_W_RAW > 32) ? 32 : WD_W_RAW;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'd1);
  localparam bit              WD_ON   = (TIMEOUT_CYCLES != 0);

  // State encoding equals the one-hot grant vector, so grant is the state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last;        // index of the master that last completed
  logic              w_last_nxt;
  logic [WD_W-1:0]   r_wd;
  logic              r_timeout_error;
  logic              r_timeout_master;

  logic              w_req0;
  logic              w_req1;
  logic              w_own_req;     // request of the current owner
  logic              w_other_req;   // request of the non-owner
  logic              w_hit;
  logic              w_done;
  logic              w_owner_idx;

  // A master requests when it drives a read strobe or any byte write strobe.
  function automatic logic is_request(input logic nrd, input logic [3:0] nwr);
    return (nrd == 1'b0) || (nwr != 4'b1111);
  endfunction

  assign w_req0 = is_request(m0_nrd, m0_nwr);
  assign w_req1 = is_request(m1_nrd, m1_nwr);

  // Owner-relative view of the requests and the watchdog/complete condition.
  always_comb begin
    w_own_req   = 1'b0;
    w_other_req = 1'b0;
    w_owner_idx = 1'b0;
    case (r_state)
      ST_OWN0: begin
        w_own_req   = w_req0;
        w_other_req = w_req1;
        w_owner_idx = 1'b0;
      end
      ST_OWN1: begin
        w_own_req   = w_req1;
        w_other_req = w_req0;
        w_owner_idx = 1'b1;
      end
      default: begin
        w_own_req   = 1'b0;
        w_other_req = 1'b0;
        w_owner_idx = 1'b0;
      end
    endcase
    w_hit  = WD_ON && (r_state != ST_IDLE) && (r_wd == WD_LAST);
    w_done = w_own_req && (s_ready || w_hit);
  end

  // Next-state and round-robin pointer update.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          // Tie: the master that did not complete last goes first.
          w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        end else if (w_req0) begin
          w_state_nxt = ST_OWN0;
        end else if (w_req1) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (w_done) begin
          // The owner's request at this edge is the one being completed, so
          // only the other master can be handed the bus directly.
          w_last_nxt = w_owner_idx;
          if (w_other_req) begin
            w_state_nxt = (r_state == ST_OWN0) ? ST_OWN1 : ST_OWN0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (!w_own_req) begin
          // Access abandoned before completion: release without credit.
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Round-robin pointer; reset to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // Watchdog: restarts on any ownership change or completion, otherwise
  // counts granted cycles the slave leaves unacknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd <= '0;
    end else if ((w_state_nxt != r_state) || w_done) begin
      r_wd <= '0;
    end else if (WD_ON && (r_state != ST_IDLE) && !s_ready) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // Sticky timeout flag; a timeout on the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout_error  <= 1'b0;
      r_timeout_master <= 1'b0;
    end else if (w_done && w_hit) begin
      r_timeout_error  <= 1'b1;
      r_timeout_master <= w_owner_idx;
    end else if (clear_error) begin
      r_timeout_error  <= 1'b0;
    end
  end

  // Slave bus mux: the owner drives the bus, idle parks it inactive.
  always_comb begin
    s_address  = 32'h0;
    s_data_out = 32'h0;
    s_nrd      = 1'b1;
    s_nwr      = 4'b1111;
    case (r_state)
      ST_OWN0: begin
        s_address  = m0_address;
        s_data_out = m0_data_out;
        s_nrd      = m0_nrd;
        s_nwr      = m0_nwr;
      end
      ST_OWN1: begin
        s_address  = m1_address;
        s_data_out = m1_data_out;
        s_nrd      = m1_nrd;
        s_nwr      = m1_nwr;
      end
      default: begin
        s_address  = 32'h0;
        s_data_out = 32'h0;
        s_nrd      = 1'b1;
        s_nwr      = 4'b1111;
      end
    endcase
  end

  // Master responses: ready only to the owner; error data on a watchdog hit.
  always_comb begin
    m0_ready   = (r_state == ST_OWN0) && w_req0 && (s_ready || w_hit);
    m1_ready   = (r_state == ST_OWN1) && w_req1 && (s_ready || w_hit);
    m0_data_in = ((r_state == ST_OWN0) && w_hit) ? ERROR_DATA : s_data_in;
    m1_data_in = ((r_state == ST_OWN1) && w_hit) ? ERROR_DATA : s_data_in;
  end

  assign grant          = r_state;
  assign timeout_error  = r_timeout_error;
  assign timeout_master = r_timeout_master;

endmodule
